// File: rtl/dma_priority_timing_ctrl.sv
// Single-transfer DMA sequencer: arbitrates DREQ, handshakes HRQ/HLDA and times S0..S5.
// Optional build macro ROTATING_PRIORITY_EN enables the rotating-priority pointer.
module dma_priority_timing_ctrl #(
    parameter int CHANNELS = 4
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [CHANNELS-1:0] DREQ,
    input  logic [CHANNELS-1:0] chMask,
    input  logic                cmdDisable,
    input  logic                cmdRotPri,
    input  logic [1:0]          xferType,
    input  logic                HLDA,
    input  logic                EOP_N,
    input  logic                tcReached,
    output logic                HRQ,
    output logic [CHANNELS-1:0] DACK,
    output logic                AEN,
    output logic                MEMR_N,
    output logic                MEMW_N,
    output logic                IOR_N,
    output logic                IOW_N,
    output logic                programCondition,
    output logic                loadAddr,
    output logic                incrTemporaryAddressReg,
    output logic                decrTemporaryWordCountReg,
    output logic                updateCurrentAddressReg,
    output logic                updateCurrentWordCountReg,
    output logic                intEOP,
    output logic [2:0]          fsm_state
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S0   = 3'd1,
        S1   = 3'd2,
        S2   = 3'd3,
        S3   = 3'd4,
        S4   = 3'd5,
        S5   = 3'd6
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   ch;
    logic [CW-1:0]   win;
    logic            eop_latch;
    logic [CHANNELS-1:0] elig;
    logic            any_elig;
    logic            in_xfer;
    logic [CW-1:0]   start;

    assign elig     = DREQ & ~chMask & {CHANNELS{~cmdDisable}};
    assign any_elig = |elig;
    assign in_xfer  = (state == S1) || (state == S2) || (state == S3) ||
                      (state == S4) || (state == S5);

`ifdef ROTATING_PRIORITY_EN
    logic [CW-1:0] rot_ptr;

    assign start = cmdRotPri ? rot_ptr : '0;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            rot_ptr <= '0;
        end else if (state == S5 && HLDA) begin
            rot_ptr <= (ch == CW'(CHANNELS - 1)) ? '0 : ch + 1'b1;
        end
    end
`else
    logic unused_rot_pri;

    assign unused_rot_pri = cmdRotPri;
    assign start          = '0;
`endif

    // Descending scan so the last hit is the closest channel at or after the start point.
    always_comb begin
        win = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(start) + k) % CHANNELS;
            if (elig[idx]) begin
                win = CW'(idx);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (any_elig) state_next = S0;
            S0: begin
                if (!DREQ[ch])  state_next = IDLE;
                else if (HLDA)  state_next = S1;
            end
            S1: state_next = HLDA ? S2 : IDLE;
            S2: state_next = HLDA ? S3 : IDLE;
            S3: state_next = HLDA ? S4 : IDLE;
            S4: state_next = HLDA ? S5 : IDLE;
            S5: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Channel is captured only on the grant; the EOP latch lives only within S1..S5.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ch        <= '0;
            eop_latch <= 1'b0;
        end else begin
            if (state == IDLE && any_elig) begin
                ch <= win;
            end
            if (in_xfer && !HLDA) begin
                eop_latch <= 1'b0;
            end else begin
                case (state)
                    S1, S2, S3: eop_latch <= eop_latch | ~EOP_N;
                    S4:         eop_latch <= eop_latch | ~EOP_N | tcReached;
                    default:    eop_latch <= 1'b0;
                endcase
            end
        end
    end

    always_comb begin
        HRQ                       = 1'b0;
        DACK                      = '0;
        AEN                       = 1'b0;
        MEMR_N                    = 1'b1;
        MEMW_N                    = 1'b1;
        IOR_N                     = 1'b1;
        IOW_N                     = 1'b1;
        programCondition          = (state == IDLE) && !HLDA;
        loadAddr                  = 1'b0;
        incrTemporaryAddressReg   = 1'b0;
        decrTemporaryWordCountReg = 1'b0;
        updateCurrentAddressReg   = 1'b0;
        updateCurrentWordCountReg = 1'b0;
        intEOP                    = 1'b0;

        if (state == S0 || in_xfer) begin
            HRQ = 1'b1;
        end
        if (in_xfer) begin
            AEN      = 1'b1;
            DACK[ch] = 1'b1;
        end
        if (state == S2 || state == S3) begin
            IOR_N  = !(xferType == 2'b01);
            MEMR_N = !(xferType == 2'b10);
        end
        if (state == S3) begin
            MEMW_N = !(xferType == 2'b01);
            IOW_N  = !(xferType == 2'b10);
        end
        if (state == S1) begin
            loadAddr = 1'b1;
        end
        if (state == S4) begin
            incrTemporaryAddressReg   = 1'b1;
            decrTemporaryWordCountReg = 1'b1;
        end
        // A hold release in S5 is an abort, so the commit pulses are withheld.
        if (state == S5 && HLDA) begin
            updateCurrentAddressReg   = 1'b1;
            updateCurrentWordCountReg = 1'b1;
            intEOP                    = eop_latch;
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_dma_priority_timing_ctrl.sv
// Directed bench for dma_priority_timing_ctrl; rotating expectations follow ROTATING_PRIORITY_EN.
module tb_dma_priority_timing_ctrl;

    logic       CLK;
    logic       RESET_N;
    logic [3:0] DREQ;
    logic [3:0] chMask;
    logic       cmdDisable;
    logic       cmdRotPri;
    logic [1:0] xferType;
    logic       HLDA;
    logic       EOP_N;
    logic       tcReached;
    logic       HRQ;
    logic [3:0] DACK;
    logic       AEN;
    logic       MEMR_N;
    logic       MEMW_N;
    logic       IOR_N;
    logic       IOW_N;
    logic       programCondition;
    logic       loadAddr;
    logic       incrTemporaryAddressReg;
    logic       decrTemporaryWordCountReg;
    logic       updateCurrentAddressReg;
    logic       updateCurrentWordCountReg;
    logic       intEOP;
    logic [2:0] fsm_state;

    int n_cmp;
    int n_err;
    logic [15:0] exp_v;
    logic [15:0] obs;

    // {HRQ, AEN, DACK, MEMR_N, MEMW_N, IOR_N, IOW_N, loadAddr, incr, decr, updA, updW, intEOP}
    assign obs = {HRQ, AEN, DACK, MEMR_N, MEMW_N, IOR_N, IOW_N, loadAddr,
                  incrTemporaryAddressReg, decrTemporaryWordCountReg,
                  updateCurrentAddressReg, updateCurrentWordCountReg, intEOP};

    dma_priority_timing_ctrl #(.CHANNELS(4)) dut (
        .CLK                       (CLK),
        .RESET_N                   (RESET_N),
        .DREQ                      (DREQ),
        .chMask                    (chMask),
        .cmdDisable                (cmdDisable),
        .cmdRotPri                 (cmdRotPri),
        .xferType                  (xferType),
        .HLDA                      (HLDA),
        .EOP_N                     (EOP_N),
        .tcReached                 (tcReached),
        .HRQ                       (HRQ),
        .DACK                      (DACK),
        .AEN                       (AEN),
        .MEMR_N                    (MEMR_N),
        .MEMW_N                    (MEMW_N),
        .IOR_N                     (IOR_N),
        .IOW_N                     (IOW_N),
        .programCondition          (programCondition),
        .loadAddr                  (loadAddr),
        .incrTemporaryAddressReg   (incrTemporaryAddressReg),
        .decrTemporaryWordCountReg (decrTemporaryWordCountReg),
        .updateCurrentAddressReg   (updateCurrentAddressReg),
        .updateCurrentWordCountReg (updateCurrentWordCountReg),
        .intEOP                    (intEOP),
        .fsm_state                 (fsm_state)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // One clock; inputs are driven and outputs sampled at the falling edge.
    task automatic step();
        @(negedge CLK);
    endtask

    // From an IDLE sample point with HLDA=0: runs one transfer up to the S5 sample point.
    task automatic xfer_to_s5(input logic [3:0] req, input logic eop_s0,
                              input logic eop_s2, input logic tc_s4);
        DREQ = req;
        step();                 // S0
        HLDA  = 1'b1;
        EOP_N = ~eop_s0;
        step();                 // S1
        EOP_N = 1'b1;
        step();                 // S2
        EOP_N = ~eop_s2;
        step();                 // S3
        EOP_N = 1'b1;
        step();                 // S4
        tcReached = tc_s4;
        step();                 // S5
        tcReached = 1'b0;
    endtask

    task automatic finish_xfer(input logic [3:0] req_after);
        DREQ = req_after;
        step();                 // IDLE
        HLDA = 1'b0;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; DREQ = 4'hF; HLDA = 1'b1;
        step(); step();
        exp_v = {1'b0, 1'b0, 4'b0000, 4'b1111, 6'b000000};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL reset_outputs: got %h want %h", obs, exp_v); end
        n_cmp++; if (programCondition !== 1'b0) begin n_err++; $display("FAIL reset_progcond_hlda: got %b want 0", programCondition); end
        n_cmp++; if (fsm_state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
        RESET_N = 1'b1; DREQ = 4'h0; HLDA = 1'b0;
        step();
        n_cmp++; if (programCondition !== 1'b1) begin n_err++; $display("FAIL idle_progcond: got %b want 1", programCondition); end
        n_cmp++; if (HRQ !== 1'b0) begin n_err++; $display("FAIL idle_hrq: got %b want 0", HRQ); end
    endtask

    task automatic test_single();
        xferType = 2'b01; DREQ = 4'b0100;
        step();                 // S0
        exp_v = {1'b1, 1'b0, 4'b0000, 4'b1111, 6'b000000};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL single_s0: got %h want %h", obs, exp_v); end
        step();                 // still S0, waiting for HLDA
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL single_s0_wait: got %h want %h", obs, exp_v); end
        HLDA = 1'b1;
        step();                 // S1
        exp_v = {1'b1, 1'b1, 4'b0100, 4'b1111, 6'b100000};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL single_s1: got %h want %h", obs, exp_v); end
        step();                 // S2
        exp_v = {1'b1, 1'b1, 4'b0100, 4'b1101, 6'b000000};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL single_s2: got %h want %h", obs, exp_v); end
        step();                 // S3
        exp_v = {1'b1, 1'b1, 4'b0100, 4'b1001, 6'b000000};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL single_s3: got %h want %h", obs, exp_v); end
        step();                 // S4
        exp_v = {1'b1, 1'b1, 4'b0100, 4'b1111, 6'b011000};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL single_s4: got %h want %h", obs, exp_v); end
        DREQ = 4'b0000;
        step();                 // S5
        exp_v = {1'b1, 1'b1, 4'b0100, 4'b1111, 6'b000110};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL single_s5: got %h want %h", obs, exp_v); end
        step();                 // IDLE
        exp_v = {1'b0, 1'b0, 4'b0000, 4'b1111, 6'b000000};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL single_idle: got %h want %h", obs, exp_v); end
        HLDA = 1'b0;
    endtask

    task automatic test_tc_eop();
        xferType = 2'b10;
        xfer_to_s5(4'b0001, 1'b1, 1'b0, 1'b0);
        exp_v = {1'b1, 1'b1, 4'b0001, 4'b1111, 6'b000110};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL eop_in_s0_ignored: got %h want %h", obs, exp_v); end
        finish_xfer(4'b0000);
        xfer_to_s5(4'b0001, 1'b0, 1'b0, 1'b1);
        exp_v = {1'b1, 1'b1, 4'b0001, 4'b1111, 6'b000111};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL tc_inteop: got %h want %h", obs, exp_v); end
        finish_xfer(4'b0000);
        exp_v = {1'b0, 1'b0, 4'b0000, 4'b1111, 6'b000000};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL tc_idle_after: got %h want %h", obs, exp_v); end
        xfer_to_s5(4'b0001, 1'b0, 1'b1, 1'b0);
        exp_v = {1'b1, 1'b1, 4'b0001, 4'b1111, 6'b000111};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL eop_s2_inteop: got %h want %h", obs, exp_v); end
        finish_xfer(4'b0000);
        xfer_to_s5(4'b0001, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (intEOP !== 1'b0) begin n_err++; $display("FAIL eop_latch_cleared: got %b want 0", intEOP); end
        finish_xfer(4'b0000);
    endtask

    task automatic test_priority();
        logic [3:0] exp_dack [3];
        RESET_N = 1'b0; DREQ = 4'b0000; step(); RESET_N = 1'b1; step();
        cmdRotPri = 1'b0;
        for (int i = 0; i < 3; i++) begin
            xfer_to_s5(4'b1010, 1'b0, 1'b0, 1'b0);
            n_cmp++; if (DACK !== 4'b0010) begin n_err++; $display("FAIL fixed_prio_%0d: got %b want 0010", i, DACK); end
            finish_xfer(4'b1010);
            n_cmp++; if (HRQ !== 1'b0) begin n_err++; $display("FAIL fixed_gap_hrq_%0d: got %b want 0", i, HRQ); end
        end
        RESET_N = 1'b0; DREQ = 4'b0000; step(); RESET_N = 1'b1; step();
        cmdRotPri = 1'b1;
`ifdef ROTATING_PRIORITY_EN
        exp_dack = '{4'b0010, 4'b1000, 4'b0010};
`else
        exp_dack = '{4'b0010, 4'b0010, 4'b0010};
`endif
        for (int i = 0; i < 3; i++) begin
            xfer_to_s5(4'b1010, 1'b0, 1'b0, 1'b0);
            n_cmp++; if (DACK !== exp_dack[i]) begin n_err++; $display("FAIL rot_prio_%0d: got %b want %b", i, DACK, exp_dack[i]); end
            finish_xfer(4'b1010);
        end
        DREQ = 4'b0000; cmdRotPri = 1'b0;
        step();
    endtask

    task automatic test_abort();
        xferType = 2'b01; DREQ = 4'b0100;
        step(); HLDA = 1'b1;    // S0
        step(); step(); step(); // S1, S2, S3
        exp_v = {1'b1, 1'b1, 4'b0100, 4'b1001, 6'b000000};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL abort_in_s3: got %h want %h", obs, exp_v); end
        HLDA = 1'b0; DREQ = 4'b0000;
        step();
        exp_v = {1'b0, 1'b0, 4'b0000, 4'b1111, 6'b000000};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL abort_idle: got %h want %h", obs, exp_v); end
        step();
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL abort_no_update: got %h want %h", obs, exp_v); end
        DREQ = 4'b0010;
        step();                 // S0
        n_cmp++; if (HRQ !== 1'b1) begin n_err++; $display("FAIL drop_s0_hrq_up: got %b want 1", HRQ); end
        DREQ = 4'b0000;
        step();
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL drop_s0_idle: got %h want %h", obs, exp_v); end
        step();
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL drop_s0_no_dack: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_mask_disable();
        chMask = 4'b0001; DREQ = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (HRQ !== 1'b0) begin n_err++; $display("FAIL masked_hrq_%0d: got %b want 0", i, HRQ); end
        end
        chMask = 4'b0000; DREQ = 4'b0000; cmdDisable = 1'b1;
        step();
        DREQ = 4'b0010;
        step(); step();
        n_cmp++; if (HRQ !== 1'b0) begin n_err++; $display("FAIL disabled_hrq: got %b want 0", HRQ); end
        cmdDisable = 1'b0;
        step();
        n_cmp++; if (HRQ !== 1'b1) begin n_err++; $display("FAIL enabled_hrq: got %b want 1", HRQ); end
        DREQ = 4'b0000;
        step();
        n_cmp++; if (HRQ !== 1'b0) begin n_err++; $display("FAIL enabled_drop: got %b want 0", HRQ); end
    endtask

    task automatic test_disable_midxfer();
        xferType = 2'b00; DREQ = 4'b1000;
        step(); HLDA = 1'b1;    // S0
        step();                 // S1
        exp_v = {1'b1, 1'b1, 4'b1000, 4'b1111, 6'b100000};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL verify_s1: got %h want %h", obs, exp_v); end
        cmdDisable = 1'b1;
        step();                 // S2: verify has no strobes
        exp_v = {1'b1, 1'b1, 4'b1000, 4'b1111, 6'b000000};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL verify_s2: got %h want %h", obs, exp_v); end
        step(); step(); step(); // S3, S4, S5
        exp_v = {1'b1, 1'b1, 4'b1000, 4'b1111, 6'b000110};
        n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL disable_no_abort: got %h want %h", obs, exp_v); end
        finish_xfer(4'b1000);
        step();
        n_cmp++; if (HRQ !== 1'b0) begin n_err++; $display("FAIL disable_blocks_next: got %b want 0", HRQ); end
        cmdDisable = 1'b0;
        step();
        n_cmp++; if (HRQ !== 1'b1) begin n_err++; $display("FAIL disable_release: got %b want 1", HRQ); end
        DREQ = 4'b0000;
        step();
        n_cmp++; if (fsm_state !== 3'd0) begin n_err++; $display("FAIL disable_end_idle: got %0d want 0", fsm_state); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        RESET_N = 1'b0; DREQ = 4'h0; chMask = 4'h0; cmdDisable = 1'b0; cmdRotPri = 1'b0;
        xferType = 2'b01; HLDA = 1'b0; EOP_N = 1'b1; tcReached = 1'b0;
        @(negedge CLK);
        test_reset();
        test_single();
        test_tc_eop();
        test_priority();
        test_abort();
        test_mask_disable();
        test_disable_midxfer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
